mem_loader: RTL
===============

MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 Parameter: width, 57, memory columns.
REQ-002 Parameter: height, 8, memory rows.
REQ-003 Parameter: width_b, 6, column address bits.
REQ-004 Parameter: height_b, 3, row address bits.
REQ-005 Port: clk  in  1  single clock, all logic on rising edge.
REQ-006 Port: reset  in  1  synchronous, active-high reset.
REQ-007 Port: start  in  1  one-cycle command strobe, sampled only in IDLE.
REQ-008 Port: cmd_mode  in  1  0 = single-byte writes, 1 = 9-byte burst writes.
REQ-009 Port: base_w  in  width_b  starting column.
REQ-010 Port: base_h  in  height_b  starting row.
REQ-011 Port: num_writes  in  8  number of write operations in the command.
REQ-012 Port: in_data  in  8  input byte stream.
REQ-013 Port: in_valid  in  1  in_data valid.
REQ-014 Port: in_ready  out  1  loader accepts a byte; a transfer occurs when in_valid and in_ready are both high.
REQ-015 Port: write_w  out  width_b  memory write column.
REQ-016 Port: write_h  out  height_b  memory write row.
REQ-017 Port: write  out  72  packed bytes; the first byte received sits in bits [71:64].
REQ-018 Port: mode  out  1  memory write mode, equal to the latched cmd_mode.
REQ-019 Port: en  out  1  memory write enable, one cycle per write.
REQ-020 Port: busy  out  1  high in every state except IDLE.
REQ-021 Port: done  out  1  one-cycle pulse at command end.
REQ-022 Port: err  out  1  one-cycle pulse when a command is rejected.

Function
REQ-023 FSM states: IDLE, COLLECT, WRITE, FINISH.
REQ-024 IDLE to COLLECT: start=1 and num_writes!=0 and address legal; latch mode, base address, and the count.
REQ-025 Address legality: in mode 1, base_w must be ≤ width-9 and base_h ≤ height-1; in mode 0, base_w must be ≤ width-1.
REQ-026 IDLE to FINISH when start=1 and num_writes=0.
REQ-027 An illegal start asserts err for one cycle, stays in IDLE and issues no write.
REQ-028 start outside IDLE is ignored.
REQ-029 in_ready=1 only in COLLECT.
REQ-030 Each accepted byte shifts into the pack register from the MSB side.
REQ-031 Mode 0 collects 1 byte into bits [71:64] and leaves the other bits 0; mode 1 collects 9 bytes.
REQ-032 COLLECT to WRITE on the cycle the last byte of the group is accepted.
REQ-033 In WRITE, en=1 for exactly one cycle, with write_w/write_h/write/mode stable in that cycle.
REQ-034 After WRITE, decrement the count; go to COLLECT if the count is nonzero, else to FINISH.
REQ-035 Mode 0 address advance: w+1; if w=width-1, then w←0 and h←h+1, with h wrapping from height-1 to 0.
REQ-036 Mode 1 address advance: h+1; if h=height-1, then h←0 and w←w+9; if the new w > width-9, then w←0.
REQ-037 FINISH: done=1 for one cycle, then go to IDLE.
REQ-038 Throughput: mode 0 is 2 cycles per write; mode 1 is 10 cycles per write with continuous in_valid.
REQ-039 in_valid low stalls COLLECT indefinitely without losing collected bytes.

Reset
REQ-040 reset=1 forces IDLE on the next edge, including mid-command; partially collected bytes are discarded.
REQ-041 Reset values: en, in_ready, busy, done, err, mode = 0; write_w, write_h, write = 0; count and byte counter = 0.

Structure
REQ-042 A shared package/header npu_mem_pkg holds the FSM state encodings, the default width/height values, and the burst length constant (9).
REQ-043 A single sub-module mem_byte_packer (72-bit shift register, byte counter, group-full flag) is instantiated.

Verification
REQ-044 Mode 0, base (3,2), num_writes=2, bytes 0xA1, 0xB2 -> en pulses with (w=3,h=2,write[71:64]=0xA1) then (w=4,h=2,write[71:64]=0xB2); done follows.
REQ-045 Mode 1, base (0,7), num_writes=2, bytes 0x01..0x12 -> first write at (0,7) with write=0x010203040506070809; second write at (9,0) with 0x0A..0x12.
REQ-046 Mode 1 start with base_w=49 -> err pulse, no en, busy stays 0.
REQ-047 Mode 0 base (56,7), num_writes=2 -> writes at (56,7) then (0,0).
REQ-048 Mode 1, reset after 4 bytes, then a new mode 0 command -> no en before reset, and the first write of the new command carries only a new byte.
REQ-049 in_valid toggled 1/0 every cycle in mode 1 -> identical write data, en at the 18th accepted-byte boundary.

Source files
------------

// File: rtl/npu_mem_pkg.sv
// Shared definitions for the memory loader: default geometry, burst length, FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package npu_mem_pkg;

  localparam int WIDTH_DEF    = 57;  // memory columns
  localparam int HEIGHT_DEF   = 8;   // memory rows
  localparam int WIDTH_B_DEF  = 6;   // column address bits
  localparam int HEIGHT_B_DEF = 3;   // row address bits

  // A burst write covers nine adjacent columns, one byte each.
  localparam int BURST_LEN = 9;
  localparam int PACK_W    = 8 * BURST_LEN;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_FINISH  = 2'd3
  } ld_state_e;

endpackage

// File: rtl/mem_byte_packer.sv
// Byte packer: shifts accepted bytes into a 72-bit word, counts bytes, flags group completion.
// Latency: byte visible in data one cycle after push; grp_full is combinational on the last push.
// Backpressure: none internally; the caller only pushes on an accepted transfer.
// Ports: clk/reset (sync, active-high); clr drops the group; push+din add a byte;
//        burst selects a 9-byte group (else 1); data is the packed word; grp_full marks the last byte.
module mem_byte_packer
  import npu_mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              push,
  input  logic              burst,
  input  logic [7:0]        din,
  output logic [PACK_W-1:0] data,
  output logic              grp_full
);

  localparam logic [3:0] LAST_IDX = 4'(BURST_LEN - 1);

  logic [PACK_W-1:0] data_q, data_d;
  logic [3:0]        cnt_q, cnt_d;

  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (clr) begin
      data_d = '0;
      cnt_d  = '0;
    end else if (push) begin
      // Older bytes move toward the MSB, so after a full burst the first byte is on top.
      data_d = {data_q[PACK_W-9:0], din};
      cnt_d  = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign data     = data_q;
  assign grp_full = push && (cnt_q == (burst ? LAST_IDX : 4'd0));

endmodule

// File: rtl/mem_loader.sv
// Memory loader: collects a byte stream and issues single-byte or 9-byte burst memory writes.
// Latency: mode 0 one write per 2 cycles, mode 1 one write per 10 cycles with continuous in_valid.
// Backpressure: in_ready is high only while collecting; in_valid low stalls without losing bytes.
// Ports: start/cmd_mode/base_w/base_h/num_writes describe a command (sampled in IDLE only);
//        in_data/in_valid/in_ready is the byte stream; write_w/write_h/write/mode/en drive the
//        memory; busy/done/err report command status.
module mem_loader
  import npu_mem_pkg::*;
#(
  parameter int width    = WIDTH_DEF,
  parameter int height   = HEIGHT_DEF,
  parameter int width_b  = WIDTH_B_DEF,
  parameter int height_b = HEIGHT_B_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                cmd_mode,
  input  logic [width_b-1:0]  base_w,
  input  logic [height_b-1:0] base_h,
  input  logic [7:0]          num_writes,
  input  logic [7:0]          in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [width_b-1:0]  write_w,
  output logic [height_b-1:0] write_h,
  output logic [PACK_W-1:0]   write,
  output logic                mode,
  output logic                en,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam logic [width_b-1:0]  W_LAST      = width_b'(width - 1);
  localparam logic [width_b-1:0]  W_BURST_MAX = width_b'(width - BURST_LEN);
  localparam logic [height_b-1:0] H_LAST      = height_b'(height - 1);
  localparam logic [width_b:0]    BURST_STEP  = (width_b + 1)'(BURST_LEN);

  ld_state_e           state_q, state_d;
  logic [width_b-1:0]  w_q, w_d;
  logic [height_b-1:0] h_q, h_d;
  logic                mode_q, mode_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                err_q, err_d;

  logic                cmd_legal;
  logic [width_b:0]    w_sum;
  logic                pack_clr, pack_push, pack_full;
  logic [PACK_W-1:0]   pack_data;

  mem_byte_packer u_packer (
    .clk      (clk),
    .reset    (reset),
    .clr      (pack_clr),
    .push     (pack_push),
    .burst    (mode_q),
    .din      (in_data),
    .data     (pack_data),
    .grp_full (pack_full)
  );

  // A burst must fit all nine columns inside the row.
  assign cmd_legal = cmd_mode ? ((base_w <= W_BURST_MAX) && (base_h <= H_LAST))
                              : (base_w <= W_LAST);

  always_comb begin
    state_d   = state_q;
    w_d       = w_q;
    h_d       = h_q;
    mode_d    = mode_q;
    cnt_d     = cnt_q;
    err_d     = 1'b0;
    pack_clr  = 1'b0;
    pack_push = 1'b0;
    w_sum     = {1'b0, w_q} + BURST_STEP;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (num_writes == 8'd0) begin
            state_d = ST_FINISH;
          end else if (cmd_legal) begin
            state_d = ST_COLLECT;
            mode_d  = cmd_mode;
            w_d     = base_w;
            h_d     = base_h;
            cnt_d   = num_writes;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_COLLECT: begin
        pack_push = in_valid;
        if (pack_full) state_d = ST_WRITE;
      end

      ST_WRITE: begin
        pack_clr = 1'b1;
        cnt_d    = cnt_q - 8'd1;
        state_d  = (cnt_q == 8'd1) ? ST_FINISH : ST_COLLECT;
        if (mode_q) begin
          // Bursts walk down a column strip, then step nine columns right.
          if (h_q == H_LAST) begin
            h_d = '0;
            w_d = (w_sum > {1'b0, W_BURST_MAX}) ? '0 : w_sum[width_b-1:0];
          end else begin
            h_d = h_q + 1'b1;
          end
        end else begin
          // Single bytes walk along a row, then wrap to the next row.
          if (w_q == W_LAST) begin
            w_d = '0;
            h_d = (h_q == H_LAST) ? '0 : h_q + 1'b1;
          end else begin
            w_d = w_q + 1'b1;
          end
        end
      end

      ST_FINISH: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      w_q     <= '0;
      h_q     <= '0;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      h_q     <= h_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign in_ready = (state_q == ST_COLLECT);
  assign en       = (state_q == ST_WRITE);
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_FINISH);
  assign err      = err_q;
  assign mode     = mode_q;
  assign write_w  = w_q;
  assign write_h  = h_q;
  // A single byte is presented in the top lane with the rest of the word zero.
  assign write    = mode_q ? pack_data : {pack_data[7:0], {(PACK_W - 8){1'b0}}};

endmodule
